// File: rtl/turf_udp_resp_arbiter_if.sv
// Stream interfaces for the UDP response path: a header channel carrying
// {ip[63:32], port[31:16], length[15:0]} and a payload channel with keep/last.

interface turf_udp_hdr_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

interface turf_udp_data_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/turf_udp_resp_arbiter.sv
// Two-source UDP response arbiter. Port 0 carries ack responses, port 1 nack
// responses. A whole packet (header then payload up to tlast) is granted to one
// source at a time and muxed combinationally onto the single transmitter path.

module turf_udp_resp_arbiter #(
    parameter int NACK_PRIORITY = 0  // 0: round-robin, 1: port 1 always wins a tie
) (
    input  logic            aclk,
    input  logic            areset,
    turf_udp_hdr_if.slave   s0_udphdr,
    turf_udp_data_if.slave  s0_udpdata,
    turf_udp_hdr_if.slave   s1_udphdr,
    turf_udp_data_if.slave  s1_udpdata,
    turf_udp_hdr_if.master  m_udphdr,
    turf_udp_data_if.master m_udpdata,
    output logic [1:0]      grant_o,
    output logic [15:0]     pkt_count0_o,
    output logic [15:0]     pkt_count1_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HEADER = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;

    localparam bit NACK_WINS = (NACK_PRIORITY != 0);

    logic [1:0]  state;
    logic [1:0]  grant;       // one-hot owner, 00 while idle
    logic        last_grant;  // 1 = port 1 was granted most recently
    logic [15:0] count0;
    logic [15:0] count1;

    logic in_header;
    logic in_data;
    logic owner1;
    logic any_hdr;
    logic pick1;
    logic hdr_fire;
    logic last_fire;

    // Reset gates the phase qualifiers so every valid/ready is low while
    // areset is high, even before the first reset edge has been seen.
    assign in_header = !areset && (state == ST_HEADER);
    assign in_data   = !areset && (state == ST_DATA);
    assign owner1    = grant[1];

    // Port 1 wins if it is alone, if nack priority is on, or if port 0 was
    // the most recent owner.
    assign any_hdr = s0_udphdr.tvalid || s1_udphdr.tvalid;
    assign pick1   = s1_udphdr.tvalid && (!s0_udphdr.tvalid || NACK_WINS || !last_grant);

    // Header path: zero-latency mux from the registered owner.
    assign m_udphdr.tdata   = owner1 ? s1_udphdr.tdata : s0_udphdr.tdata;
    assign m_udphdr.tvalid  = in_header && (owner1 ? s1_udphdr.tvalid : s0_udphdr.tvalid);
    assign s0_udphdr.tready = in_header && grant[0] && m_udphdr.tready;
    assign s1_udphdr.tready = in_header && grant[1] && m_udphdr.tready;

    // Payload path: keep and data pass through untouched.
    assign m_udpdata.tdata   = owner1 ? s1_udpdata.tdata : s0_udpdata.tdata;
    assign m_udpdata.tkeep   = owner1 ? s1_udpdata.tkeep : s0_udpdata.tkeep;
    assign m_udpdata.tlast   = owner1 ? s1_udpdata.tlast : s0_udpdata.tlast;
    assign m_udpdata.tvalid  = in_data && (owner1 ? s1_udpdata.tvalid : s0_udpdata.tvalid);
    assign s0_udpdata.tready = in_data && grant[0] && m_udpdata.tready;
    assign s1_udpdata.tready = in_data && grant[1] && m_udpdata.tready;

    assign hdr_fire  = m_udphdr.tvalid && m_udphdr.tready;
    assign last_fire = m_udpdata.tvalid && m_udpdata.tready && m_udpdata.tlast;

    assign grant_o      = grant;
    assign pkt_count0_o = count0;
    assign pkt_count1_o = count1;

    // Packet-level FSM: pick an owner in IDLE, forward its header, then its
    // payload until the tlast handshake releases the grant.
    always_ff @(posedge aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (areset) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_hdr) begin
                        grant <= pick1 ? 2'b10 : 2'b01;
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (hdr_fire) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (last_fire) begin
                        state      <= ST_IDLE;
                        grant      <= 2'b00;
                        last_grant <= owner1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Completed-packet counters; the 16-bit add wraps FFFF -> 0000 by itself.
    always_ff @(posedge aclk) begin
        if (areset) begin
            count0 <= 16'd0;
            count1 <= 16'd0;
        end else if (last_fire) begin
            if (owner1) begin
                count1 <= count1 + 16'd1;
            end else begin
                count0 <= count0 + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_turf_udp_resp_arbiter.sv
// Scoreboard bench for turf_udp_resp_arbiter. Two instances are built, one
// round-robin and one nack-priority; both see the same source stimulus and
// `sel` chooses which one the sources and the monitor follow.
`timescale 1ns/1ps

module tb_turf_udp_resp_arbiter;

    typedef struct packed {
        logic [1:0]  owner;
        logic [63:0] hdr;
    } hdr_exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } dat_exp_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    logic sel    = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Source and sink stimulus shared by both instances.
    logic [1:0][63:0] src_hdr_data  = '0;
    logic [1:0]       src_hdr_valid = '0;
    logic [1:0][63:0] src_dat_data  = '0;
    logic [1:0][7:0]  src_dat_keep  = '0;
    logic [1:0]       src_dat_last  = '0;
    logic [1:0]       src_dat_valid = '0;
    logic             sink_hdr_ready = 1'b1;
    logic             sink_dat_ready = 1'b1;
    logic             dat_rand       = 1'b0;

    // Per-instance observed outputs, indexed by instance.
    logic [1:0][1:0]  hdr_ready;
    logic [1:0][1:0]  dat_ready;
    logic [1:0]       m_hv;
    logic [1:0][63:0] m_hd;
    logic [1:0]       m_dv;
    logic [1:0][63:0] m_dd;
    logic [1:0][7:0]  m_dk;
    logic [1:0]       m_dl;
    logic [1:0][1:0]  grant;
    logic [1:0][15:0] cnt0;
    logic [1:0][15:0] cnt1;

    hdr_exp_t hq[$];
    dat_exp_t dq[$];
    int       hdr_cyc_q[$];
    int       dat_cyc_q[$];
    int       start_cyc[2];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : u
        turf_udp_hdr_if  s0_h ();
        turf_udp_hdr_if  s1_h ();
        turf_udp_data_if s0_d ();
        turf_udp_data_if s1_d ();
        turf_udp_hdr_if  m_h ();
        turf_udp_data_if m_d ();

        assign s0_h.tdata  = src_hdr_data[0];
        assign s0_h.tvalid = src_hdr_valid[0];
        assign s1_h.tdata  = src_hdr_data[1];
        assign s1_h.tvalid = src_hdr_valid[1];
        assign s0_d.tdata  = src_dat_data[0];
        assign s0_d.tkeep  = src_dat_keep[0];
        assign s0_d.tlast  = src_dat_last[0];
        assign s0_d.tvalid = src_dat_valid[0];
        assign s1_d.tdata  = src_dat_data[1];
        assign s1_d.tkeep  = src_dat_keep[1];
        assign s1_d.tlast  = src_dat_last[1];
        assign s1_d.tvalid = src_dat_valid[1];
        assign m_h.tready  = sink_hdr_ready;
        assign m_d.tready  = sink_dat_ready;

        assign hdr_ready[g][0] = s0_h.tready;
        assign hdr_ready[g][1] = s1_h.tready;
        assign dat_ready[g][0] = s0_d.tready;
        assign dat_ready[g][1] = s1_d.tready;
        assign m_hv[g] = m_h.tvalid;
        assign m_hd[g] = m_h.tdata;
        assign m_dv[g] = m_d.tvalid;
        assign m_dd[g] = m_d.tdata;
        assign m_dk[g] = m_d.tkeep;
        assign m_dl[g] = m_d.tlast;

        turf_udp_resp_arbiter #(.NACK_PRIORITY(g)) dut (
            .aclk         (aclk),
            .areset       (areset),
            .s0_udphdr    (s0_h),
            .s0_udpdata   (s0_d),
            .s1_udphdr    (s1_h),
            .s1_udpdata   (s1_d),
            .m_udphdr     (m_h),
            .m_udpdata    (m_d),
            .grant_o      (grant[g]),
            .pkt_count0_o (cnt0[g]),
            .pkt_count1_o (cnt1[g])
        );
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input int p, input int i, input int n);
        return {32'hC0A8_0100 + 32'(p), 16'(5000 + i), 16'(8 * n)};
    endfunction

    function automatic logic [63:0] mk_base(input int p, input int i);
        return {8'(p + 1), 8'(i), 48'h0000_DA7A_0000};
    endfunction

    function automatic logic [7:0] mk_keep(input int p, input int i);
        return 8'hFF >> (i + 4 * p);
    endfunction

    // Expected merged output for one packet, in the order the test predicts.
    task automatic push_pkt(input int p, input logic [63:0] hdr, input int n,
                            input logic [63:0] base, input logic [7:0] last_keep);
        hdr_exp_t he;
        dat_exp_t de;
        he.owner = (p == 1) ? 2'b10 : 2'b01;
        he.hdr   = hdr;
        hq.push_back(he);
        for (int b = 0; b < n; b++) begin
            de.data = base + 64'(b);
            de.keep = (b == n - 1) ? last_keep : 8'hFF;
            de.last = (b == n - 1);
            dq.push_back(de);
        end
    endtask

    // Called just after a negedge drive; returns at the negedge following the
    // handshake edge, or early with ok=0 if reset hits or the bound expires.
    task automatic wait_ready(input int p, input bit is_data, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            #1;
            if (areset) return;
            if (is_data ? dat_ready[sel][p] : hdr_ready[sel][p]) begin
                @(negedge aclk);
                ok = 1'b1;
                return;
            end
            @(negedge aclk);
        end
        checks++;
        errors++;
        $display("FAIL wait_ready_timeout: port %0d data=%0d got no tready, expected one within 400 cycles", p, is_data);
    endtask

    // Source driver; must be entered at a negedge.
    task automatic send_pkt(input int p, input logic [63:0] hdr, input int n,
                            input logic [63:0] base, input logic [7:0] last_keep);
        bit ok;
        src_hdr_data[p]  = hdr;
        src_hdr_valid[p] = 1'b1;
        start_cyc[p]     = cyc + 1;
        wait_ready(p, 1'b0, ok);
        src_hdr_valid[p] = 1'b0;
        for (int b = 0; b < n && ok; b++) begin
            src_dat_data[p]  = base + 64'(b);
            src_dat_keep[p]  = (b == n - 1) ? last_keep : 8'hFF;
            src_dat_last[p]  = (b == n - 1);
            src_dat_valid[p] = 1'b1;
            wait_ready(p, 1'b1, ok);
        end
        src_dat_valid[p] = 1'b0;
        src_dat_last[p]  = 1'b0;
    endtask

    task automatic reset_dut();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check({name, "_hq_empty"}, 80'(hq.size()), 80'(0));
        check({name, "_dq_empty"}, 80'(dq.size()), 80'(0));
    endtask

    // Sink back-pressure pattern.
    initial begin
        forever begin
            @(negedge aclk);
            if (dat_rand) sink_dat_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks that
    // only the granted source ever sees a tready.
    initial begin
        hdr_exp_t he;
        dat_exp_t de;
        dat_exp_t got;
        forever begin
            @(negedge aclk);
            #1;
            if (!areset) begin
                if (m_hv[sel] && sink_hdr_ready) begin
                    hdr_cyc_q.push_back(cyc + 1);
                    if (hq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL hdr_unexpected: got %h expected no header", m_hd[sel]);
                    end else begin
                        he = hq.pop_front();
                        check("hdr_data", 80'(m_hd[sel]), 80'(he.hdr));
                        check("hdr_owner", 80'(grant[sel]), 80'(he.owner));
                    end
                end
                if (m_dv[sel] && sink_dat_ready) begin
                    dat_cyc_q.push_back(cyc + 1);
                    got.data = m_dd[sel];
                    got.keep = m_dk[sel];
                    got.last = m_dl[sel];
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_unexpected: got %h expected no beat", got);
                    end else begin
                        de = dq.pop_front();
                        check("data_beat", 80'(got), 80'(de));
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (hdr_ready[sel][p] || dat_ready[sel][p])
                        check($sformatf("ready_owner%0d", p), 80'(grant[sel][p]), 80'(1));
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish within 200us");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with both headers offered so readies are exercised.
        src_hdr_valid = 2'b11;
        repeat (3) @(negedge aclk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_grant", 80'(grant[g]), 80'(0));
            check("rst_counts", 80'({cnt0[g], cnt1[g]}), 80'(0));
            check("rst_valids", 80'({m_hv[g], m_dv[g]}), 80'(0));
            check("rst_readies", 80'({hdr_ready[g], dat_ready[g]}), 80'(0));
        end
        src_hdr_valid = 2'b00;
        @(negedge aclk);
        areset = 1'b0;

        // Port 0 alone: header at cycle 1, data at cycles 2-3.
        sel = 1'b0;
        hdr_cyc_q.delete();
        dat_cyc_q.delete();
        push_pkt(0, 64'hC0A8_0001_1F90_0010, 2, 64'h1111_2222_3333_0000, 8'h3F);
        send_pkt(0, 64'hC0A8_0001_1F90_0010, 2, 64'h1111_2222_3333_0000, 8'h3F);
        repeat (2) @(negedge aclk);
        #1;
        check("t1_hdr_count", 80'(hdr_cyc_q.size()), 80'(1));
        if (hdr_cyc_q.size() == 1)
            check("t1_hdr_cycle", 80'(hdr_cyc_q[0] - start_cyc[0]), 80'(1));
        check("t1_dat_count", 80'(dat_cyc_q.size()), 80'(2));
        if (dat_cyc_q.size() == 2) begin
            check("t1_dat0_cycle", 80'(dat_cyc_q[0] - start_cyc[0]), 80'(2));
            check("t1_dat1_cycle", 80'(dat_cyc_q[1] - start_cyc[0]), 80'(3));
        end
        check("t1_cnt0", 80'(cnt0[0]), 80'(16'd1));
        check("t1_cnt1", 80'(cnt1[0]), 80'(16'd0));
        check("t1_grant_idle", 80'(grant[0]), 80'(0));
        check_drained("t1");

        // Round-robin: both sources always pending, grants alternate 0,1,0,1...
        reset_dut();
        sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, mk_hdr(0, i, 1), 1, mk_base(0, i), mk_keep(0, i));
            push_pkt(1, mk_hdr(1, i, 1), 1, mk_base(1, i), mk_keep(1, i));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) send_pkt(0, mk_hdr(0, i, 1), 1, mk_base(0, i), mk_keep(0, i));
            end
            begin
                for (int i = 0; i < 4; i++) send_pkt(1, mk_hdr(1, i, 1), 1, mk_base(1, i), mk_keep(1, i));
            end
        join
        repeat (2) @(negedge aclk);
        #1;
        check("t2_cnt0", 80'(cnt0[0]), 80'(16'd4));
        check("t2_cnt1", 80'(cnt1[0]), 80'(16'd4));
        check_drained("t2");

        // Nack priority: all four port-1 packets precede any port-0 packet.
        reset_dut();
        sel = 1'b1;
        for (int i = 0; i < 4; i++) push_pkt(1, mk_hdr(1, i, 1), 1, mk_base(1, i), mk_keep(1, i));
        for (int i = 0; i < 4; i++) push_pkt(0, mk_hdr(0, i, 1), 1, mk_base(0, i), mk_keep(0, i));
        fork
            begin
                for (int i = 0; i < 4; i++) send_pkt(0, mk_hdr(0, i, 1), 1, mk_base(0, i), mk_keep(0, i));
            end
            begin
                for (int i = 0; i < 4; i++) send_pkt(1, mk_hdr(1, i, 1), 1, mk_base(1, i), mk_keep(1, i));
            end
        join
        repeat (2) @(negedge aclk);
        #1;
        check("t3_cnt0", 80'(cnt0[1]), 80'(16'd4));
        check("t3_cnt1", 80'(cnt1[1]), 80'(16'd4));
        check_drained("t3");

        // Back-pressure on a 3-beat port-1 packet with port 0 waiting.
        reset_dut();
        sel = 1'b1;
        hdr_cyc_q.delete();
        dat_cyc_q.delete();
        push_pkt(1, mk_hdr(1, 7, 3), 3, mk_base(1, 7), 8'h07);
        push_pkt(0, mk_hdr(0, 7, 2), 2, mk_base(0, 7), 8'hF0);
        dat_rand = 1'b1;
        fork
            send_pkt(1, mk_hdr(1, 7, 3), 3, mk_base(1, 7), 8'h07);
            send_pkt(0, mk_hdr(0, 7, 2), 2, mk_base(0, 7), 8'hF0);
        join
        dat_rand = 1'b0;
        sink_dat_ready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        check("t4_hdr_count", 80'(hdr_cyc_q.size()), 80'(2));
        check("t4_dat_count", 80'(dat_cyc_q.size()), 80'(5));
        if (hdr_cyc_q.size() == 2 && dat_cyc_q.size() >= 3)
            check("t4_gap_after_tlast", 80'(hdr_cyc_q[1] - dat_cyc_q[2]), 80'(2));
        check("t4_cnt0", 80'(cnt0[1]), 80'(16'd1));
        check("t4_cnt1", 80'(cnt1[1]), 80'(16'd1));
        check_drained("t4");

        // Reset in the middle of a payload, then a clean packet.
        @(negedge aclk);
        push_pkt(0, mk_hdr(0, 9, 4), 4, mk_base(0, 9), 8'hFF);
        fork
            send_pkt(0, mk_hdr(0, 9, 4), 4, mk_base(0, 9), 8'hFF);
            begin
                repeat (3) @(negedge aclk);
                areset = 1'b1;
                @(negedge aclk);
                #1;
                check("t5_valids", 80'({m_hv[1], m_dv[1]}), 80'(0));
                check("t5_readies", 80'({hdr_ready[1], dat_ready[1]}), 80'(0));
                check("t5_grant", 80'(grant[1]), 80'(0));
                check("t5_counts", 80'({cnt0[1], cnt1[1]}), 80'(0));
                @(negedge aclk);
                areset = 1'b0;
            end
        join
        check("t5_hq_after_abort", 80'(hq.size()), 80'(0));
        check("t5_dq_after_abort", 80'(dq.size()), 80'(3));
        dq.delete();
        push_pkt(0, mk_hdr(0, 10, 2), 2, mk_base(0, 10), 8'h01);
        send_pkt(0, mk_hdr(0, 10, 2), 2, mk_base(0, 10), 8'h01);
        repeat (2) @(negedge aclk);
        #1;
        check("t5_cnt0", 80'(cnt0[1]), 80'(16'd1));
        check("t5_cnt1", 80'(cnt1[1]), 80'(16'd0));
        check_drained("t5");

        // Counter wrap: preload 65534, then two packets -> FFFF, 0000.
        reset_dut();
        sel = 1'b0;
        force u[0].dut.count0 = 16'hFFFE;
        #1;
        release u[0].dut.count0;
        @(negedge aclk);
        push_pkt(0, mk_hdr(0, 11, 1), 1, mk_base(0, 11), 8'hFF);
        send_pkt(0, mk_hdr(0, 11, 1), 1, mk_base(0, 11), 8'hFF);
        repeat (2) @(negedge aclk);
        #1;
        check("t6_cnt0_ffff", 80'(cnt0[0]), 80'(16'hFFFF));
        @(negedge aclk);
        push_pkt(0, mk_hdr(0, 12, 1), 1, mk_base(0, 12), 8'h80);
        send_pkt(0, mk_hdr(0, 12, 1), 1, mk_base(0, 12), 8'h80);
        repeat (2) @(negedge aclk);
        #1;
        check("t6_cnt0_wrap", 80'(cnt0[0]), 80'(16'h0000));
        check("t6_cnt1", 80'(cnt1[0]), 80'(16'h0000));
        check_drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
